// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd_pkg
// Description : Shared constants, state encodings and helpers for the 4-bit
//               HD44780-style LCD sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // HD44780 command codes used by the power-on sequence
  localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] CLEAR        = 8'h01;

  // Default timing in 12 MHz cycles
  localparam int unsigned T_PWR_DEF   = 180000;
  localparam int unsigned T_INIT1_DEF = 49200;
  localparam int unsigned T_INIT2_DEF = 1200;
  localparam int unsigned T_CMD_DEF   = 480;
  localparam int unsigned T_CLR_DEF   = 19680;
  localparam int unsigned T_SU_DEF    = 1;
  localparam int unsigned T_EH_DEF    = 3;
  localparam int unsigned T_HD_DEF    = 1;
  localparam int unsigned T_NIB_DEF   = 12;

  // Init table: steps 0..3 are single nibbles (carried in the high half),
  // steps 4..7 are full bytes.
  localparam logic [2:0] INIT_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_TX_HI    = 3'd1,
    S_GAP      = 3'd2,
    S_TX_LO    = 3'd3,
    S_WAIT     = 3'd4,
    S_IDLE     = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_E_HI  = 2'd2,
    TX_HOLD  = 2'd3
  } tx_state_t;

  // A zero-length phase is stretched to one cycle
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h30;
      3'd3:             b = 8'h20;
      3'd4:             b = FUNC_4BIT_2L;
      3'd5:             b = ENTRY_INC;
      3'd6:             b = DISP_ON;
      default:          b = CLEAR;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : One timed nibble strobe: SETUP -> E_HI -> HOLD. Data and RS
//               are captured at SETUP entry and held until the next start.
//               done is high in the final HOLD cycle so the parent can move
//               on at the same edge the strobe finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_SU = T_SU_DEF,
  parameter int unsigned T_EH = T_EH_DEF,
  parameter int unsigned T_HD = T_HD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic [3:0] sf_d,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       done
);

  localparam int unsigned P_SU = at_least_one(T_SU);
  localparam int unsigned P_EH = at_least_one(T_EH);
  localparam int unsigned P_HD = at_least_one(T_HD);
  localparam int unsigned TW   = $clog2(max2(max2(P_SU, P_EH), P_HD) + 1);

  tx_state_t         state;
  logic [TW-1:0]     cnt;

  // Strobe sequencer; every phase counts down from its length to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      sf_d   <= 4'h0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            state  <= TX_SETUP;
            cnt    <= TW'(P_SU);
            sf_d   <= nib;
            lcd_rs <= rs;
          end
        end
        TX_SETUP: begin
          if (cnt == TW'(1)) begin
            state <= TX_E_HI;
            cnt   <= TW'(P_EH);
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        TX_E_HI: begin
          if (cnt == TW'(1)) begin
            state <= TX_HOLD;
            cnt   <= TW'(P_HD);
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        TX_HOLD: begin
          if (cnt == TW'(1)) begin
            state <= TX_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        default: begin
          state <= TX_IDLE;
          cnt   <= '0;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

  assign done = (state == TX_HOLD) && (cnt == TW'(1));

endmodule
`default_nettype wire

// File: rtl/lcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_seq_ctrl
// Description : HD44780 4-bit sequencer. Runs the power-on init table, then
//               accepts command/data bytes over valid/ready and sends each as
//               high nibble, gap, low nibble, then a command-dependent wait.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF,
  parameter int unsigned T_SU    = T_SU_DEF,
  parameter int unsigned T_EH    = T_EH_DEF,
  parameter int unsigned T_HD    = T_HD_DEF,
  parameter int unsigned T_NIB   = T_NIB_DEF
) (
  input  logic       CLK12,
  input  logic       RSTn,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_E,
  output logic [3:0] SF_D
);

  localparam int unsigned P_PWR   = at_least_one(T_PWR);
  localparam int unsigned P_INIT1 = at_least_one(T_INIT1);
  localparam int unsigned P_INIT2 = at_least_one(T_INIT2);
  localparam int unsigned P_CMD   = at_least_one(T_CMD);
  localparam int unsigned P_CLR   = at_least_one(T_CLR);
  localparam int unsigned P_NIB   = at_least_one(T_NIB);
  // Sized for the longest wait so a small T_PWR cannot truncate T_CLR
  localparam int unsigned P_MAX   = max2(max2(max2(P_PWR, P_INIT1), max2(P_INIT2, P_CMD)),
                                         max2(P_CLR, P_NIB));
  localparam int unsigned CW      = $clog2(P_MAX + 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic          r_init;
  logic [2:0]    r_idx;
  logic [7:0]    r_byte;
  logic          r_rs;

  logic          tx_start;
  logic [3:0]    tx_nib;
  logic          tx_rs;
  logic          tx_done;

  logic          w_pwr_end;
  logic          w_gap_end;
  logic          w_wait_end;
  logic          w_accept;
  logic          w_init_more;
  logic          w_single;
  logic [2:0]    w_next_idx;
  logic [7:0]    w_next_byte;
  logic [CW-1:0] w_wait_len;

  assign w_pwr_end   = (state == S_PWR_WAIT) && (cnt == CW'(1));
  assign w_gap_end   = (state == S_GAP)      && (cnt == CW'(1));
  assign w_wait_end  = (state == S_WAIT)     && (cnt == CW'(1));
  assign w_accept    = req_valid && req_ready;
  assign w_init_more = r_init && (r_idx != INIT_LAST);
  assign w_single    = r_init && !r_idx[2];
  assign w_next_idx  = (state == S_PWR_WAIT) ? 3'd0 : (r_idx + 3'd1);
  assign w_next_byte = init_byte(w_next_idx);

  // Post-byte wait: fixed per init nibble, clear/home rule otherwise
  always_comb begin
    w_wait_len = CW'(P_CMD);
    if (w_single) begin
      if (r_idx == 3'd0)      w_wait_len = CW'(P_INIT1);
      else if (r_idx == 3'd1) w_wait_len = CW'(P_INIT2);
      else                    w_wait_len = CW'(P_CMD);
    end else if (!r_rs && (r_byte <= 8'h03)) begin
      w_wait_len = CW'(P_CLR);
    end
  end

  // Strobe launch is combinational so the nibble starts on the same edge the
  // sequencer changes state, keeping the accept-to-ready latency exact
  always_comb begin
    tx_start = 1'b0;
    tx_nib   = w_next_byte[7:4];
    tx_rs    = 1'b0;
    if (w_pwr_end || (w_wait_end && w_init_more)) begin
      tx_start = 1'b1;
    end else if (w_accept) begin
      tx_start = 1'b1;
      tx_nib   = req_data[7:4];
      tx_rs    = req_rs;
    end else if (w_gap_end) begin
      tx_start = 1'b1;
      tx_nib   = r_byte[3:0];
      tx_rs    = r_rs;
    end
  end

  // Top-level sequencer: power wait, init table, user writes, waits
  always_ff @(posedge CLK12) begin
    if (!RSTn) begin
      state     <= S_PWR_WAIT;
      cnt       <= CW'(P_PWR);
      r_init    <= 1'b1;
      r_idx     <= 3'd0;
      r_byte    <= 8'h00;
      r_rs      <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_PWR_WAIT: begin
          if (w_pwr_end) begin
            state  <= S_TX_HI;
            cnt    <= '0;
            r_idx  <= w_next_idx;
            r_byte <= w_next_byte;
            r_rs   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_TX_HI: begin
          if (tx_done) begin
            if (w_single) begin
              state <= S_WAIT;
              cnt   <= w_wait_len;
            end else begin
              state <= S_GAP;
              cnt   <= CW'(P_NIB);
            end
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            state <= S_TX_LO;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_TX_LO: begin
          if (tx_done) begin
            state <= S_WAIT;
            cnt   <= w_wait_len;
          end
        end
        S_WAIT: begin
          if (w_wait_end) begin
            if (w_init_more) begin
              state  <= S_TX_HI;
              cnt    <= '0;
              r_idx  <= w_next_idx;
              r_byte <= w_next_byte;
              r_rs   <= 1'b0;
            end else begin
              state     <= S_IDLE;
              cnt       <= '0;
              r_init    <= 1'b0;
              init_done <= 1'b1;
              req_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            state     <= S_TX_HI;
            cnt       <= '0;
            r_byte    <= req_data;
            r_rs      <= req_rs;
            req_ready <= 1'b0;
          end
        end
        default: begin
          state     <= S_PWR_WAIT;
          cnt       <= CW'(P_PWR);
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  lcd_nibble_tx #(
    .T_SU (T_SU),
    .T_EH (T_EH),
    .T_HD (T_HD)
  ) u_nibble_tx (
    .clk    (CLK12),
    .rst_n  (RSTn),
    .start  (tx_start),
    .nib    (tx_nib),
    .rs     (tx_rs),
    .sf_d   (SF_D),
    .lcd_rs (LCD_RS),
    .lcd_e  (LCD_E),
    .done   (tx_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_lcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_seq_ctrl
// Description : Self-checking bench for lcd_seq_ctrl with shortened timing.
//               A pulse monitor records every LCD_E strobe; the reference
//               model predicts strobes, latencies and init timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_seq_ctrl;

  localparam int T_PWR = 20, T_INIT1 = 10, T_INIT2 = 5, T_CMD = 8, T_CLR = 15;
  localparam int T_SU = 1, T_EH = 3, T_HD = 1, T_NIB = 12;
  localparam int STROBE = T_SU + T_EH + T_HD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  wire        req_ready, init_done, lcd_rs, lcd_e;
  wire  [3:0] sf_d;

  always #5 clk = ~clk;

  lcd_seq_ctrl #(
    .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
    .T_CLR(T_CLR), .T_SU(T_SU), .T_EH(T_EH), .T_HD(T_HD), .T_NIB(T_NIB)
  ) dut (
    .CLK12(clk), .RSTn(rstn), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
    .LCD_RS(lcd_rs), .LCD_E(lcd_e), .SF_D(sf_d)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- strobe monitor ----------------
  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         len;
    longint     rise;
    bit         viol;
  } pulse_t;

  pulse_t     obs[$];
  pulse_t     cur;
  logic       p_e = 1'b0;
  logic       p_rs = 1'b0;
  logic [3:0] p_d = 4'h0;
  longint     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each E pulse; flag any RS/SF_D change while E is high or on
  // the samples adjacent to its edges
  always @(negedge clk) begin
    if (!rstn) begin
      p_e = 1'b0;
      cur.len = 0;
    end else begin
      if (lcd_e && !p_e) begin
        cur.rs   = lcd_rs;
        cur.d    = sf_d;
        cur.len  = 0;
        cur.rise = cyc;
        cur.viol = (lcd_rs !== p_rs) || (sf_d !== p_d);
      end else if ((p_e || lcd_e) && ((lcd_rs !== p_rs) || (sf_d !== p_d))) begin
        cur.viol = 1'b1;
      end
      if (lcd_e) cur.len++;
      if (!lcd_e && p_e) obs.push_back(cur);
      p_e = lcd_e;
    end
    p_rs = lcd_rs;
    p_d  = sf_d;
  end

  // ---------------- reference model ----------------
  function automatic int model_wait(input logic rs, input logic [7:0] d);
    return (!rs && d <= 8'h03) ? T_CLR : T_CMD;
  endfunction

  function automatic int model_latency(input logic rs, input logic [7:0] d);
    return 2 * STROBE + T_NIB + model_wait(rs, d);
  endfunction

  task automatic check_pulse(input string name, input pulse_t p, input logic rs,
                             input logic [3:0] d, input longint rise);
    chk({name, " nibble"}, {p.rs, p.d}, {rs, d});
    chk({name, " e_len"}, p.len, T_EH);
    chk({name, " rise"}, p.rise, rise);
    chk({name, " stable"}, p.viol, 0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge with rstn low; releases reset and checks the init run
  task automatic check_init(input string tag);
    logic [3:0] exp_nib[$];
    longint     exp_rise[$];
    longint     rel, t;
    int         k;
    bit         nz;
    logic [7:0] bytes[4];
    int         nib_wait[4];
    bytes    = '{8'h28, 8'h06, 8'h0C, 8'h01};
    nib_wait = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
    // Timeline: strobe = setup+E+hold, then wait or gap
    rel = cyc;
    t   = rel + T_PWR;
    for (int i = 0; i < 4; i++) begin
      exp_nib.push_back((i == 3) ? 4'h2 : 4'h3);
      exp_rise.push_back(t + T_SU);
      t += STROBE + nib_wait[i];
    end
    for (int i = 0; i < 4; i++) begin
      exp_nib.push_back(bytes[i][7:4]);
      exp_rise.push_back(t + T_SU);
      t += STROBE + T_NIB;
      exp_nib.push_back(bytes[i][3:0]);
      exp_rise.push_back(t + T_SU);
      t += STROBE + model_wait(1'b0, bytes[i]);
    end
    obs.delete();
    rstn = 1'b1;
    nz = 1'b0;
    for (k = 0; k < T_PWR; k++) begin
      if ({lcd_e, lcd_rs, sf_d, req_ready, init_done} !== 8'h00) nz = 1'b1;
      @(negedge clk);
    end
    chk({tag, " pwr quiet"}, nz, 0);
    chk({tag, " first setup"}, {lcd_e, lcd_rs, sf_d}, {1'b0, 1'b0, 4'h3});
    while (init_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " init_done time"}, k, t - rel);
    chk({tag, " ready at init end"}, req_ready, 1);
    chk({tag, " init pulses"}, obs.size(), exp_nib.size());
    if (obs.size() == exp_nib.size())
      for (int i = 0; i < exp_nib.size(); i++)
        check_pulse($sformatf("%s init%0d", tag, i), obs[i], 1'b0, exp_nib[i], exp_rise[i]);
  endtask

  task automatic write_check(input string tag, input logic rs, input logic [7:0] d,
                             input logic [3:0] ehi, input logic [3:0] elo, input int elat);
    bit     ok;
    int     k;
    longint acc;
    wait_ready(ok);
    chk({tag, " ready before"}, ok, 1);
    obs.delete();
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
    req_rs    = 1'($urandom);
    req_data  = 8'($urandom);
    chk({tag, " busy"}, req_ready, 0);
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, k, elat);
    chk({tag, " pulses"}, obs.size(), 2);
    if (obs.size() == 2) begin
      check_pulse({tag, " hi"}, obs[0], rs, ehi, acc + T_SU);
      check_pulse({tag, " lo"}, obs[1], rs, elo, acc + STROBE + T_NIB + T_SU);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit         ok;
    int         k;
    longint     acc, acc2;
    logic       rs;
    logic [7:0] d;

    vecs[0] = '{1'b1, 8'h41, 4'h4, 4'h1, 30};
    vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 37};
    vecs[2] = '{1'b1, 8'h01, 4'h0, 4'h1, 30};
    vecs[3] = '{1'b0, 8'h03, 4'h0, 4'h3, 37};
    vecs[4] = '{1'b0, 8'h04, 4'h0, 4'h4, 30};
    vecs[5] = '{1'b0, 8'h00, 4'h0, 4'h0, 37};
    vecs[6] = '{1'b1, 8'hFF, 4'hF, 4'hF, 30};
    vecs[7] = '{1'b0, 8'h80, 4'h8, 4'h0, 30};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {lcd_e, lcd_rs, sf_d, req_ready, init_done}, 8'h00);
    check_init("boot");

    // Fixed vectors
    foreach (vecs[i])
      write_check($sformatf("vec%0d", i), vecs[i].rs, vecs[i].d, vecs[i].hi,
                  vecs[i].lo, vecs[i].lat);

    // Valid held during busy: ignored, then accepted the cycle ready returns
    wait_ready(ok);
    chk("b2b ready", ok, 1);
    obs.delete();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h41;
    @(negedge clk);
    acc      = cyc;
    req_data = 8'h42;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("b2b first latency", k, model_latency(1'b1, 8'h41));
    chk("b2b ignored while busy", obs.size(), 2);
    @(negedge clk);
    acc2 = cyc;
    chk("b2b accepted", req_ready, 0);
    req_valid = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("b2b second latency", k, model_latency(1'b1, 8'h42));
    chk("b2b pulses", obs.size(), 4);
    if (obs.size() == 4) begin
      check_pulse("b2b 2nd hi", obs[2], 1'b1, 4'h4, acc + model_latency(1'b1, 8'h41) + 1 + T_SU);
      check_pulse("b2b 2nd lo", obs[3], 1'b1, 4'h2, acc2 + STROBE + T_NIB + T_SU);
    end

    // Randomised writes against the model, biased toward the clear/home edge
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      d  = (i % 3 == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      write_check($sformatf("rnd%0d", i), rs, d, d[7:4], d[3:0], model_latency(rs, d));
    end

    // Reset during E high of a user write
    wait_ready(ok);
    chk("rst ready", ok, 1);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (lcd_e !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst saw E high", lcd_e, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst abort outputs", {lcd_e, lcd_rs, sf_d, req_ready, init_done}, 8'h00);
    @(negedge clk);
    check_init("replay");
    write_check("post_rst", 1'b1, 8'h41, 4'h4, 4'h1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
